// File: rtl/maxpool2x2_stream_pkg.sv
// Shared LeNet constants and types for the 2x2 max-pooling stage.
// Layers instantiating the pool take their dimensions from here.
package maxpool2x2_stream_pkg;

  localparam int LENET_BITWIDTH = 16;

  // Layer 1 pool input: 28x28x6
  localparam int L1_WIDTH   = 28;
  localparam int L1_HEIGHT  = 28;
  localparam int L1_CHANNEL = 6;

  // Layer 2 pool input: 10x10x16
  localparam int L2_WIDTH   = 10;
  localparam int L2_HEIGHT  = 10;
  localparam int L2_CHANNEL = 16;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } row_phase_e;

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Input and output stream of the pooling stage.
// Handshake: a beat transfers on a rising edge where valid && ready; while
// valid is high and ready is low the producer holds data (and last) stable.
interface maxpool2x2_stream_if
  import maxpool2x2_stream_pkg::*;
#(
  parameter int BITWIDTH = LENET_BITWIDTH
);
  logic [BITWIDTH-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/maxpool2x2_stream_signed_max2.sv
// Combinational signed maximum of two operands; ties return either (equal) value.
module signed_max2
  import maxpool2x2_stream_pkg::*;
#(
  parameter int BITWIDTH = LENET_BITWIDTH
) (
  input  logic signed [BITWIDTH-1:0] a_i,
  input  logic signed [BITWIDTH-1:0] b_i,
  output logic signed [BITWIDTH-1:0] max_o
);
  assign max_o = (a_i > b_i) ? a_i : b_i;
endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max pool: horizontal pair max per beat, half-row
// line buffer of pair maxima on even rows, window result emitted on odd rows.
module maxpool2x2_stream
  import maxpool2x2_stream_pkg::*;
#(
  parameter int BITWIDTH    = LENET_BITWIDTH,
  parameter int DATAWIDTH   = L1_WIDTH,
  parameter int DATAHEIGHT  = L1_HEIGHT,
  parameter int DATACHANNEL = L1_CHANNEL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  maxpool2x2_stream_if.slave   bus,
  output row_phase_e           phase_o
);
  localparam int HALFW = DATAWIDTH / 2;
  localparam int HW    = (HALFW > 1) ? $clog2(HALFW) : 1;
  localparam int CW    = HW + 1;
  localparam int RW    = (DATAHEIGHT > 1) ? $clog2(DATAHEIGHT) : 1;
  localparam int NW    = (DATACHANNEL > 1) ? $clog2(DATACHANNEL) : 1;

  if (((DATAWIDTH % 2) != 0) || ((DATAHEIGHT % 2) != 0)) begin : g_bad_dims
    $fatal(1, "maxpool2x2_stream: DATAWIDTH and DATAHEIGHT must be even");
  end

  row_phase_e                 state_q;
  logic [CW-1:0]              col_q, col_d;
  logic [RW-1:0]              row_q, row_d;
  logic [NW-1:0]              ch_q, ch_d;
  logic                       out_valid_q, out_last_q;
  logic signed [BITWIDTH-1:0] out_data_q;
  logic signed [BITWIDTH-1:0] pair_q;
  logic signed [BITWIDTH-1:0] linebuf_q [HALFW];

  logic signed [BITWIDTH-1:0] in_s, pmax, wmax;
  logic [HW-1:0]              lb_idx;
  logic                       accept, col_last, row_last, ch_last;

  assign in_s     = $signed(bus.in_data);
  assign lb_idx   = col_q[CW-1:1];
  assign col_last = (col_q == CW'(DATAWIDTH - 1));
  assign row_last = (row_q == RW'(DATAHEIGHT - 1));
  assign ch_last  = (ch_q == NW'(DATACHANNEL - 1));

  // Stall every input while a result waits, so one output register suffices.
  assign bus.in_ready = !(out_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  signed_max2 #(.BITWIDTH(BITWIDTH)) u_pair_max (
    .a_i   (pair_q),
    .b_i   (in_s),
    .max_o (pmax)
  );

  signed_max2 #(.BITWIDTH(BITWIDTH)) u_window_max (
    .a_i   (linebuf_q[lb_idx]),
    .b_i   (pmax),
    .max_o (wmax)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d = '0;
          ch_d  = ch_last ? '0 : ch_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EVEN_ROW;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ch_q  <= ch_d;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (accept) begin
        if (col_last) begin
          state_q <= (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
        end
        // A new result overrides the drain so back-to-back outputs have no bubble.
        if (col_q[0] && (state_q == ODD_ROW)) begin
          out_data_q  <= wmax;
          out_valid_q <= 1'b1;
          out_last_q  <= ch_last && row_last && col_last;
        end
      end
    end
  end

  // Datapath storage is always written before it is read, so it has no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!col_q[0]) begin
        pair_q <= in_s;
      end else if (state_q == EVEN_ROW) begin
        linebuf_q[lb_idx] <= pmax;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign phase_o       = state_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: a small 4x4x2 instance for directed cases and
// a 28x28x6 instance for random traffic, both against a window-max model.
module tb_maxpool2x2_stream;
  import maxpool2x2_stream_pkg::*;

  localparam int BW  = LENET_BITWIDTH;
  localparam int AW  = 4;
  localparam int AH  = 4;
  localparam int AC  = 2;
  localparam int BWD = L1_WIDTH;
  localparam int BHT = L1_HEIGHT;
  localparam int BCH = L1_CHANNEL;
  localparam int WAIT_LIMIT = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maxpool2x2_stream_if #(.BITWIDTH(BW)) ifa ();
  maxpool2x2_stream_if #(.BITWIDTH(BW)) ifb ();
  row_phase_e phase_a, phase_b;

  maxpool2x2_stream #(
    .BITWIDTH(BW), .DATAWIDTH(AW), .DATAHEIGHT(AH), .DATACHANNEL(AC)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .phase_o(phase_a)
  );

  maxpool2x2_stream #(
    .BITWIDTH(BW), .DATAWIDTH(BWD), .DATAHEIGHT(BHT), .DATACHANNEL(BCH)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .phase_o(phase_b)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [BW:0] exp_a_q[$];
  logic [BW:0] exp_b_q[$];
  logic [BW:0] pool_exp[$];
  logic signed [BW-1:0] frm[];
  int rdy_mode_a = 0;   // 0: ready high, 1: random, 2: held by the test

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- output ready drivers ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_mode_a == 0) ifa.out_ready = 1'b1;
    else if (rdy_mode_a == 1) ifa.out_ready = ($urandom_range(0, 3) != 0);
    ifb.out_ready = ($urandom_range(0, 2) != 0);
  end

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (rst_n && ifa.out_valid && ifa.out_ready) begin
      if (exp_a_q.size() == 0) check_eq("a_unexpected_out", {ifa.out_last, ifa.out_data}, 32'h1_0000_0);
      else check_eq("a_out", {ifa.out_last, ifa.out_data}, exp_a_q.pop_front());
    end
    if (rst_n && ifb.out_valid && ifb.out_ready) begin
      if (exp_b_q.size() == 0) check_eq("b_unexpected_out", {ifb.out_last, ifb.out_data}, 32'h1_0000_0);
      else check_eq("b_out", {ifb.out_last, ifb.out_data}, exp_b_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  task automatic model_push(input bit sel, input int w, input int h, input int c);
    logic signed [BW-1:0] m;
    logic lst;
    int base;
    pool_exp.delete();
    for (int ci = 0; ci < c; ci++) begin
      for (int pr = 0; pr < h / 2; pr++) begin
        for (int pc = 0; pc < w / 2; pc++) begin
          base = ci * h * w + 2 * pr * w + 2 * pc;
          m = frm[base];
          if (frm[base + 1] > m) m = frm[base + 1];
          if (frm[base + w] > m) m = frm[base + w];
          if (frm[base + w + 1] > m) m = frm[base + w + 1];
          lst = (ci == c - 1) && (pr == h / 2 - 1) && (pc == w / 2 - 1);
          if (sel) exp_b_q.push_back({lst, m});
          else begin
            exp_a_q.push_back({lst, m});
            pool_exp.push_back({lst, m});
          end
        end
      end
    end
  endtask

  // ---------------- drivers (called and returning at a falling edge) ----------------
  task automatic send_a(input logic signed [BW-1:0] d);
    int waited = 0;
    ifa.in_data  = d;
    ifa.in_valid = 1'b1;
    while (!ifa.in_ready && waited < WAIT_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= WAIT_LIMIT) check_eq("a_in_ready_timeout", 32'(waited), 32'(WAIT_LIMIT - 1));
    @(negedge clk);
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic signed [BW-1:0] d);
    int waited = 0;
    ifb.in_data  = d;
    ifb.in_valid = 1'b1;
    while (!ifb.in_ready && waited < WAIT_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= WAIT_LIMIT) check_eq("b_in_ready_timeout", 32'(waited), 32'(WAIT_LIMIT - 1));
    @(negedge clk);
    ifb.in_valid = 1'b0;
  endtask

  task automatic send_frame_a(input int first, input int gap_max);
    for (int i = first; i < AW * AH * AC; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_a(frm[i]);
    end
  endtask

  task automatic fill_random(input int n);
    frm = new[n];
    for (int i = 0; i < n; i++) frm[i] = BW'($urandom);
  endtask

  task automatic wait_drained(input string tag);
    int t = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, 32'(exp_a_q.size() + exp_b_q.size()), 0);
  endtask

  // ---------------- main sequence ----------------
  int spec_rows[16] = '{1, 5, 2, 0, 3, 4, 9, 8, 0, 0, 7, 1, 6, 2, 3, 3};
  int sgn_rows[8]   = '{-3, -1, -5, -6, -7, -2, -8, -9};

  initial begin
    int k;
    ifa.in_data = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    ifb.in_data = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", ifa.out_valid, 0);
    check_eq("rst_out_last", ifa.out_last, 0);
    check_eq("rst_out_data", ifa.out_data, 0);
    check_eq("rst_phase", phase_a, EVEN_ROW);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", ifa.in_ready, 1);

    // reference frame in channel 0, negative values in channel 1, with latency checks
    frm = new[AW * AH * AC];
    for (int i = 0; i < AW * AH; i++) frm[i] = BW'(spec_rows[i]);
    for (int i = AW * AH; i < AW * AH * AC; i++) frm[i] = BW'(-int'($urandom_range(1, 20)));
    model_push(0, AW, AH, AC);
    k = 0;
    for (int i = 0; i < AW * AH * AC; i++) begin
      send_a(frm[i]);
      if (i == AW - 1) check_eq("phase_after_row0", phase_a, ODD_ROW);
      if (((i / AW) % 2 == 1) && (i % 2 == 1)) begin
        check_eq("lat_valid", ifa.out_valid, 1);
        check_eq("lat_data_last", {ifa.out_last, ifa.out_data}, pool_exp[k]);
        k++;
      end
    end
    // second frame follows with no idle cycle
    fill_random(AW * AH * AC);
    model_push(0, AW, AH, AC);
    send_frame_a(0, 0);
    wait_drained("drain_back_to_back");

    // output stall of 3 cycles on the first result
    frm = new[AW * AH * AC];
    for (int i = 0; i < AW * AH; i++) frm[i] = BW'(spec_rows[i]);
    for (int i = AW * AH; i < AW * AH * AC; i++) frm[i] = BW'($urandom_range(0, 50));
    model_push(0, AW, AH, AC);
    rdy_mode_a = 2;
    for (int i = 0; i < 6; i++) send_a(frm[i]);
    ifa.out_ready = 1'b0;
    #1;
    fork
      begin
        for (int s = 0; s < 3; s++) begin
          if (s > 0) @(negedge clk);
          check_eq("stall_in_ready", ifa.in_ready, 0);
          check_eq("stall_out_valid", ifa.out_valid, 1);
          check_eq("stall_out_data", ifa.out_data, 5);
        end
        @(posedge clk);
        #1 ifa.out_ready = 1'b1;
      end
      send_frame_a(6, 0);
    join
    rdy_mode_a = 0;
    wait_drained("drain_stall");

    // signed window
    fill_random(AW * AH * AC);
    for (int i = 0; i < 4; i++) begin
      frm[i]      = BW'(sgn_rows[i]);
      frm[AW + i] = BW'(sgn_rows[4 + i]);
    end
    model_push(0, AW, AH, AC);
    for (int i = 0; i < 6; i++) send_a(frm[i]);
    check_eq("signed_first", ifa.out_data, 16'hFFFF);
    send_frame_a(6, 0);
    wait_drained("drain_signed");

    // reset after 6 beats with a result pending
    rdy_mode_a = 2;
    ifa.out_ready = 1'b0;
    fill_random(AW * AH * AC);
    for (int i = 0; i < 6; i++) send_a(frm[i]);
    check_eq("pre_rst_valid", ifa.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", ifa.out_valid, 0);
    check_eq("midrst_in_ready", ifa.in_ready, 1);
    check_eq("midrst_phase", phase_a, EVEN_ROW);
    @(negedge clk);
    rst_n = 1'b1;
    ifa.out_ready = 1'b1;
    rdy_mode_a = 0;
    fill_random(AW * AH * AC);
    model_push(0, AW, AH, AC);
    send_frame_a(0, 0);
    wait_drained("drain_after_rst");

    // random traffic on the small instance
    rdy_mode_a = 1;
    for (int f = 0; f < 4; f++) begin
      fill_random(AW * AH * AC);
      model_push(0, AW, AH, AC);
      send_frame_a(0, 2);
    end
    wait_drained("drain_random_a");
    rdy_mode_a = 0;

    // random full LeNet layer-1 frame
    fill_random(BWD * BHT * BCH);
    model_push(1, BWD, BHT, BCH);
    for (int i = 0; i < BWD * BHT * BCH; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      send_b(frm[i]);
    end
    wait_drained("drain_random_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
